// File: rtl/fsub_core_arbiter.sv
// fsub_core_arbiter
//   Shares one subFloat64Sigs core among NREQ requesters. A round-robin
//   arbiter picks one requester, its operand pair is latched and handed to the
//   core through an ap_start/ap_ready/ap_done handshake, and the 64-bit result
//   is returned to that requester on a valid/ready response channel. A per-call
//   watchdog aborts calls whose core never finishes.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   TIMEOUT  WAIT cycles before a call is aborted (8-bit, 0 disables the watchdog)
//
// Ports
//   ap_clk, ap_rst              clock (rising edge), async active-high reset
//   req_valid/req_a/req_b       per-requester operands, lane i at [64*i +: 64]
//   req_ready                   one-cycle accept pulse to the granted requester
//   rsp_valid/rsp_ready         one-hot result handshake to the granted requester
//   rsp_data, rsp_err           shared result bus; rsp_err marks a watchdog abort
//   core_start/ready/done       handshake to the shared subtract core
//   core_a, core_b, core_zsign  registered operands and sign of operand a
//   core_return                 core result, valid while core_done = 1
//   busy                        high whenever a call is in progress
module fsub_core_arbiter #(
    parameter int          NREQ    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [64*NREQ-1:0]   req_a,
    input  logic [64*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [63:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 core_start,
    input  logic                 core_ready,
    input  logic                 core_done,
    output logic [63:0]          core_a,
    output logic [63:0]          core_b,
    output logic                 core_zsign,
    input  logic [63:0]          core_return,
    output logic                 busy
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [PW-1:0]     r_rrPtr;
    logic [PW-1:0]     r_gnt;
    logic [7:0]        r_wdCnt;
    logic [NREQ-1:0]   r_reqReady;
    logic [NREQ-1:0]   r_rspValid;
    logic [63:0]       r_rspData;
    logic              r_rspErr;
    logic              r_coreStart;
    logic [63:0]       r_coreA;
    logic [63:0]       r_coreB;

    logic              w_anyValid;
    logic [PW-1:0]     w_gntIdx;
    logic [NREQ-1:0]   w_gntOneHot;
    logic [NREQ-1:0]   w_curOneHot;
    logic [63:0]       w_selA;
    logic [63:0]       w_selB;
    logic [7:0]        w_wdNext;
    logic              w_timeout;

    // Index base+off folded back into 0..NREQ-1 (works for non power-of-two NREQ).
    function automatic logic [PW-1:0] wrapIdx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[PW-1:0];
    endfunction

    // Round-robin pick: scanning offsets from the far end down means the
    // smallest offset from r_rrPtr with a valid bit is the one that sticks.
    always_comb begin
        w_anyValid = 1'b0;
        w_gntIdx   = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            if (req_valid[wrapIdx(r_rrPtr, off)]) begin
                w_anyValid = 1'b1;
                w_gntIdx   = wrapIdx(r_rrPtr, off);
            end
        end
    end

    // Operand mux and one-hot masks for the new winner and the current owner.
    always_comb begin
        w_selA      = '0;
        w_selB      = '0;
        w_gntOneHot = '0;
        w_curOneHot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gntIdx == i[PW-1:0]) begin
                w_selA = req_a[64*i +: 64];
                w_selB = req_b[64*i +: 64];
            end
        end
        w_gntOneHot[w_gntIdx] = 1'b1;
        w_curOneHot[r_gnt]    = 1'b1;
    end

    // Watchdog fires on the TIMEOUT-th WAIT cycle; core_done always has priority.
    always_comb begin
        w_wdNext  = r_wdCnt + 8'd1;
        w_timeout = (TIMEOUT != 0) && (w_wdNext == 8'(TIMEOUT));
    end

    // State register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    // Next-state logic for IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_anyValid) w_nextState = S_ISSUE;
            S_ISSUE: if (core_ready) w_nextState = core_done ? S_RESP : S_WAIT;
            S_WAIT:  if (core_done || w_timeout) w_nextState = S_RESP;
            S_RESP:  if (rsp_ready[r_gnt]) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Datapath: operand latch, core handshake, watchdog and response registers.
    // req_ready is a single-cycle pulse, so it defaults to zero every edge.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_rrPtr     <= '0;
            r_gnt       <= '0;
            r_wdCnt     <= '0;
            r_reqReady  <= '0;
            r_rspValid  <= '0;
            r_rspData   <= '0;
            r_rspErr    <= 1'b0;
            r_coreStart <= 1'b0;
            r_coreA     <= '0;
            r_coreB     <= '0;
        end else begin
            r_reqReady <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_anyValid) begin
                        r_coreA     <= w_selA;
                        r_coreB     <= w_selB;
                        r_gnt       <= w_gntIdx;
                        r_reqReady  <= w_gntOneHot;
                        r_rrPtr     <= wrapIdx(w_gntIdx, 1);
                        r_coreStart <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (core_ready) begin
                        r_coreStart <= 1'b0;
                        r_wdCnt     <= '0;
                        if (core_done) begin
                            r_rspData  <= core_return;
                            r_rspErr   <= 1'b0;
                            r_rspValid <= w_curOneHot;
                        end
                    end
                end
                S_WAIT: begin
                    r_wdCnt <= w_wdNext;
                    if (core_done) begin
                        r_rspData  <= core_return;
                        r_rspErr   <= 1'b0;
                        r_rspValid <= w_curOneHot;
                    end else if (w_timeout) begin
                        r_rspData  <= '0;
                        r_rspErr   <= 1'b1;
                        r_rspValid <= w_curOneHot;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[r_gnt]) begin
                        r_rspValid <= '0;
                        r_rspErr   <= 1'b0;
                        r_wdCnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = r_reqReady;
    assign rsp_valid  = r_rspValid;
    assign rsp_data   = r_rspData;
    assign rsp_err    = r_rspErr;
    assign core_start = r_coreStart;
    assign core_a     = r_coreA;
    assign core_b     = r_coreB;
    assign core_zsign = r_coreA[63];
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fsub_core_arbiter.sv
// tb_fsub_core_arbiter
//   Self-checking bench for fsub_core_arbiter (NREQ = 4, TIMEOUT = 8) with a
//   behavioural subtract core whose ready delay, done delay and result are set
//   per call by the stimulus.
module tb_fsub_core_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst;
    logic [NREQ-1:0]      req_valid;
    logic [64*NREQ-1:0]   req_a;
    logic [64*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [63:0]          rsp_data;
    logic                 rsp_err;
    logic                 core_start;
    logic                 core_ready;
    logic                 core_done;
    logic [63:0]          core_a;
    logic [63:0]          core_b;
    logic                 core_zsign;
    logic [63:0]          core_return;
    logic                 busy;

    int checkCount = 0;
    int errorCount = 0;

    // Core model controls.
    int          readyDelay = 0;
    int          doneDelay  = 1;
    bit          doneEnable = 1'b1;
    bit          forceDone  = 1'b0;
    logic [63:0] retVal     = '0;
    int          startCycles = 0;
    int          doneCnt     = 0;
    int          acceptCount = 0;

    logic [63:0] laneA [NREQ];
    logic [63:0] laneB [NREQ];

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  expGnt;
        int          expIdx;
        logic [63:0] ret;
        int          dly;
    } vec_t;

    vec_t vecs [10];

    fsub_core_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .core_start  (core_start),
        .core_ready  (core_ready),
        .core_done   (core_done),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_zsign  (core_zsign),
        .core_return (core_return),
        .busy        (busy)
    );

    always #5 ap_clk = ~ap_clk;

    // Behavioural core: ap_ready after readyDelay extra start cycles, a one-cycle
    // ap_done doneDelay cycles after acceptance (0 = same cycle as ap_ready).
    always @(posedge ap_clk) begin
        #2;
        core_ready = 1'b0;
        core_done  = 1'b0;
        if (ap_rst) startCycles = 0;
        if (doneCnt > 0) begin
            doneCnt--;
            if (doneCnt == 0 && doneEnable) begin
                core_done   = 1'b1;
                core_return = retVal;
            end
        end
        if (core_start) begin
            if (startCycles == readyDelay) begin
                core_ready  = 1'b1;
                startCycles = 0;
                acceptCount++;
                if (doneDelay == 0) begin
                    if (doneEnable) begin
                        core_done   = 1'b1;
                        core_return = retVal;
                    end
                end else begin
                    doneCnt = doneDelay;
                end
            end else begin
                startCycles++;
            end
        end
        if (forceDone) core_done = 1'b1;
    end

    task automatic stepCycle();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid);
        req_valid = valid;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Completes the response handshake and confirms the return to IDLE.
    task automatic finishCall(input logic [3:0] owner);
        rsp_ready = owner;
        stepCycle();
        checkOutput("rsp_valid cleared", 64'(rsp_valid), 64'(0));
        checkOutput("busy after handshake", 64'(busy), 64'(0));
        rsp_ready = '0;
    endtask

    initial begin
        #200000;
        errorCount++;
        $display("[TB] FAIL global time limit: got running, expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int startCnt;
        int acc0;

        laneA[0] = 64'h4008000000000000;  laneB[0] = 64'h3FF0000000000000;
        laneA[1] = 64'hC010000000000000;  laneB[1] = 64'h4000000000000000;
        laneA[2] = 64'h3FE0000000000000;  laneB[2] = 64'hBFF0000000000000;
        laneA[3] = 64'h8000000000000001;  laneB[3] = 64'h0000000000000002;

        vecs[0] = '{4'b1111, 4'b0001, 0, 64'h1111000000000001, 1};
        vecs[1] = '{4'b1111, 4'b0010, 1, 64'h2222000000000002, 1};
        vecs[2] = '{4'b1111, 4'b0100, 2, 64'h3333000000000003, 1};
        vecs[3] = '{4'b1111, 4'b1000, 3, 64'h4444000000000004, 1};
        vecs[4] = '{4'b1111, 4'b0001, 0, 64'h5555000000000005, 1};
        vecs[5] = '{4'b1010, 4'b0010, 1, 64'h6666000000000006, 1};
        vecs[6] = '{4'b1010, 4'b1000, 3, 64'h7777000000000007, 1};
        vecs[7] = '{4'b0100, 4'b0100, 2, 64'h8888000000000008, 0};
        vecs[8] = '{4'b0011, 4'b0001, 0, 64'h9999000000000009, 1};
        vecs[9] = '{4'b1001, 4'b1000, 3, 64'hAAAA00000000000A, 1};

        ap_rst      = 1'b1;
        req_valid   = '0;
        rsp_ready   = '0;
        core_ready  = 1'b0;
        core_done   = 1'b0;
        core_return = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[64*i +: 64] = laneA[i];
            req_b[64*i +: 64] = laneB[i];
        end

        // Reset state.
        repeat (2) @(posedge ap_clk);
        #1;
        checkOutput("reset busy", 64'(busy), 64'(0));
        checkOutput("reset req_ready", 64'(req_ready), 64'(0));
        checkOutput("reset rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("reset core_start", 64'(core_start), 64'(0));
        checkOutput("reset core_a", core_a, 64'(0));
        checkOutput("reset rsp_data", rsp_data, 64'(0));
        checkOutput("reset rsp_err", 64'(rsp_err), 64'(0));
        ap_rst = 1'b0;
        stepCycle();

        // Round-robin order and minimum-latency calls from the vector table.
        for (int v = 0; v < 10; v++) begin
            retVal    = vecs[v].ret;
            doneDelay = vecs[v].dly;
            applyStimulus(vecs[v].valid);
            stepCycle();
            checkOutput("tbl req_ready", 64'(req_ready), 64'(vecs[v].expGnt));
            checkOutput("tbl core_start", 64'(core_start), 64'(1));
            checkOutput("tbl core_a", core_a, laneA[vecs[v].expIdx]);
            checkOutput("tbl core_b", core_b, laneB[vecs[v].expIdx]);
            checkOutput("tbl core_zsign", 64'(core_zsign), 64'(laneA[vecs[v].expIdx][63]));
            applyStimulus(4'b0000);
            stepCycle();
            checkOutput("tbl req_ready pulse", 64'(req_ready), 64'(0));
            repeat (vecs[v].dly) stepCycle();
            checkOutput("tbl rsp_valid", 64'(rsp_valid), 64'(vecs[v].expGnt));
            checkOutput("tbl rsp_data", rsp_data, vecs[v].ret);
            checkOutput("tbl rsp_err", 64'(rsp_err), 64'(0));
            finishCall(vecs[v].expGnt);
        end

        // Single requester 0 with a 5-cycle core.
        doneDelay = 5;
        retVal    = 64'h4000000000000000;
        applyStimulus(4'b0001);
        stepCycle();
        checkOutput("t1 req_ready", 64'(req_ready), 64'(4'b0001));
        applyStimulus(4'b0000);
        repeat (5) stepCycle();
        checkOutput("t1 not yet valid", 64'(rsp_valid), 64'(0));
        stepCycle();
        checkOutput("t1 rsp_valid", 64'(rsp_valid), 64'(4'b0001));
        checkOutput("t1 rsp_data", rsp_data, 64'h4000000000000000);
        checkOutput("t1 rsp_err", 64'(rsp_err), 64'(0));
        finishCall(4'b0001);

        // core_ready delayed 3 cycles: start held 4 cycles, one accepted call.
        readyDelay = 3;
        doneDelay  = 1;
        retVal     = 64'h0123456789ABCDEF;
        applyStimulus(4'b0100);
        stepCycle();
        checkOutput("t3 req_ready", 64'(req_ready), 64'(4'b0100));
        applyStimulus(4'b0000);
        startCnt = 0;
        acc0     = acceptCount;
        for (int i = 0; i < 8; i++) begin
            if (core_start) startCnt++;
            stepCycle();
        end
        checkOutput("t3 start cycles", 64'(startCnt), 64'(4));
        checkOutput("t3 accepted calls", 64'(acceptCount - acc0), 64'(1));
        checkOutput("t3 rsp_valid", 64'(rsp_valid), 64'(4'b0100));
        checkOutput("t3 rsp_data", rsp_data, 64'h0123456789ABCDEF);
        finishCall(4'b0100);
        readyDelay = 0;

        // Response back-pressure: req1 waits until the handshake completes.
        retVal = 64'hDEADBEEF00C0FFEE;
        applyStimulus(4'b1010);
        stepCycle();
        checkOutput("t5 req_ready", 64'(req_ready), 64'(4'b1000));
        applyStimulus(4'b0010);
        repeat (2) stepCycle();
        for (int i = 0; i < 10; i++) begin
            checkOutput("t5 rsp_valid held", 64'(rsp_valid), 64'(4'b1000));
            checkOutput("t5 rsp_data held", rsp_data, 64'hDEADBEEF00C0FFEE);
            checkOutput("t5 no early grant", 64'(req_ready), 64'(0));
            stepCycle();
        end
        rsp_ready = 4'b0010;
        stepCycle();
        checkOutput("t5 wrong rsp_ready ignored", 64'(rsp_valid), 64'(4'b1000));
        rsp_ready = 4'b1000;
        stepCycle();
        rsp_ready = '0;
        checkOutput("t5 rsp_valid cleared", 64'(rsp_valid), 64'(0));
        checkOutput("t5 req_ready idle", 64'(req_ready), 64'(0));
        retVal = 64'h0000000000000777;
        stepCycle();
        checkOutput("t5 req1 granted", 64'(req_ready), 64'(4'b0010));
        checkOutput("t5 core_a lane1", core_a, laneA[1]);
        applyStimulus(4'b0000);
        repeat (2) stepCycle();
        checkOutput("t5 req1 rsp_data", rsp_data, 64'h0000000000000777);
        finishCall(4'b0010);

        // Watchdog abort with a hung core, then a stray core_done in IDLE.
        doneEnable = 1'b0;
        applyStimulus(4'b0001);
        stepCycle();
        checkOutput("t4 req_ready", 64'(req_ready), 64'(4'b0001));
        applyStimulus(4'b0000);
        repeat (8) stepCycle();
        checkOutput("t4 still waiting", 64'(rsp_valid), 64'(0));
        checkOutput("t4 busy", 64'(busy), 64'(1));
        stepCycle();
        checkOutput("t4 rsp_valid", 64'(rsp_valid), 64'(4'b0001));
        checkOutput("t4 rsp_err", 64'(rsp_err), 64'(1));
        checkOutput("t4 rsp_data", rsp_data, 64'(0));
        finishCall(4'b0001);
        checkOutput("t4 rsp_err cleared", 64'(rsp_err), 64'(0));
        forceDone = 1'b1;
        stepCycle();
        forceDone = 1'b0;
        stepCycle();
        checkOutput("t4 late done busy", 64'(busy), 64'(0));
        checkOutput("t4 late done rsp_valid", 64'(rsp_valid), 64'(0));
        doneEnable = 1'b1;

        // Asynchronous reset during WAIT, then grant restarts at requester 0.
        doneDelay = 5;
        retVal    = 64'h5A5A5A5A5A5A5A5A;
        applyStimulus(4'b0010);
        stepCycle();
        checkOutput("t6 req_ready", 64'(req_ready), 64'(4'b0010));
        applyStimulus(4'b0000);
        repeat (2) stepCycle();
        checkOutput("t6 busy before reset", 64'(busy), 64'(1));
        #3;
        ap_rst = 1'b1;
        #1;
        checkOutput("t6 reset busy", 64'(busy), 64'(0));
        checkOutput("t6 reset core_a", core_a, 64'(0));
        checkOutput("t6 reset core_b", core_b, 64'(0));
        checkOutput("t6 reset core_zsign", 64'(core_zsign), 64'(0));
        checkOutput("t6 reset core_start", 64'(core_start), 64'(0));
        checkOutput("t6 reset rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("t6 reset rsp_err", 64'(rsp_err), 64'(0));
        checkOutput("t6 reset rsp_data", rsp_data, 64'(0));
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        repeat (4) stepCycle();
        checkOutput("t6 orphan done ignored", 64'(busy), 64'(0));
        checkOutput("t6 orphan rsp_valid", 64'(rsp_valid), 64'(0));
        doneDelay = 1;
        retVal    = 64'h00000000000000AB;
        applyStimulus(4'b1001);
        stepCycle();
        checkOutput("t6 first grant", 64'(req_ready), 64'(4'b0001));
        checkOutput("t6 core_a lane0", core_a, laneA[0]);
        applyStimulus(4'b0000);
        repeat (2) stepCycle();
        checkOutput("t6 rsp_valid", 64'(rsp_valid), 64'(4'b0001));
        checkOutput("t6 rsp_data", rsp_data, 64'h00000000000000AB);
        finishCall(4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
